// File: rtl/serial_ule4.sv
// Bit-serial unsigned comparator/subtractor: computes I1 - I0 LSB first through one
// carry flop, then flags LE (I0 <= I1) and EQ (I0 == I1) with a one-cycle VALID pulse.
module serial_ule4 #(
  parameter int N  = 4,
  parameter int CW = ($clog2(N + 1) > 1) ? $clog2(N + 1) : 1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [N-1:0] I0,
  input  logic [N-1:0] I1,
  output logic         READY,
  output logic         VALID,
  output logic [N-1:0] O,
  output logic         LE,
  output logic         EQ
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  o_q, o_d;
  logic          le_q, le_d;
  logic          eq_q, eq_d;

  logic          sum_bit;
  logic          carry_nxt;
  logic          last_bit;
  logic [N-1:0]  acc_shift;

  // One full-adder slice of A + ~B + 1; the carry out of the top bit is the LE flag.
  assign sum_bit   = a_q[0] ^ ~b_q[0] ^ carry_q;
  assign carry_nxt = (a_q[0] & ~b_q[0]) | (a_q[0] & carry_q) | (~b_q[0] & carry_q);
  assign last_bit  = (count_q == CW'(N - 1));

  generate
    if (N == 1) begin : g_acc_one
      assign acc_shift = sum_bit;
    end else begin : g_acc_wide
      assign acc_shift = {sum_bit, acc_q[N-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b1;
      o_q     <= '0;
      le_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      carry_q <= carry_d;
      o_q     <= o_d;
      le_q    <= le_d;
      eq_q    <= eq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers load on the final shift edge so they are already valid while VALID is high.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    count_d = count_q;
    carry_d = carry_q;
    o_d     = o_q;
    le_d    = le_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = I1;
          b_d     = I0;
          acc_d   = '0;
          count_d = '0;
          carry_d = 1'b1;
        end
      end
      SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_shift;
        carry_d = carry_nxt;
        count_d = count_q + CW'(1);
        if (last_bit) begin
          o_d  = acc_shift;
          le_d = carry_nxt;
          eq_d = (acc_shift == '0);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    READY = (state_q == IDLE);
    VALID = (state_q == DONE);
    O     = o_q;
    LE    = le_q;
    EQ    = eq_q;
  end

endmodule
